// File: rtl/fpdiv_iter.sv
// fpdiv_iter: iterative single-precision divider, out = a / b.
// Word layout {frac[31:9], exp[8:1], sign[0]}, implicit leading one, no denormals.
// Restoring radix-2 loop, one quotient bit per cycle; fixed 28-edge start-to-done latency.
// Build option FPDIV_ROUND_EN: round-to-nearest-even; when undefined the quotient is truncated.
module fpdiv_iter #(
    parameter int unsigned BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        dz,
    output logic        ovf,
    output logic        unf
);

    localparam int unsigned FW = 23;       // fraction width
    localparam int unsigned EW = 8;        // exponent width
    localparam int unsigned MW = FW + 1;   // mantissa with hidden one
    localparam int unsigned QW = 26;       // quotient bits produced
    localparam int unsigned RW = MW + 1;   // partial remainder width
    localparam int unsigned XW = 10;       // signed exponent arithmetic width
    localparam int unsigned CW = 5;        // iteration counter width

    localparam logic [CW-1:0]        LAST_ITER = CW'(QW - 1);
    localparam logic [EW-1:0]        EXP_MAX   = '1;
    localparam logic [FW-1:0]        QNAN_FRAC = 23'h400000;
    localparam logic signed [XW-1:0] E_OVF     = XW'(255);
    localparam logic signed [XW-1:0] E_UNF     = XW'(0);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

    state_t      state;
    logic [CW-1:0] iter;
    logic [RW-1:0] rem;
    logic [MW-1:0] mb;
    logic [QW-1:0] q;
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic          sgn;
    logic          spec_hit;
    logic          spec_dz;
    logic [31:0]   spec_word;
    logic [31:0]   res_word;
    logic          res_ovf;
    logic          res_unf;

    // Operand classification at the input pins
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, in_sgn;
    assign a_zero = (a[8:1] == '0);
    assign b_zero = (b[8:1] == '0);
    assign a_inf  = (a[8:1] == EXP_MAX) && (a[31:9] == '0);
    assign b_inf  = (b[8:1] == EXP_MAX) && (b[31:9] == '0);
    assign a_nan  = (a[8:1] == EXP_MAX) && (a[31:9] != '0);
    assign b_nan  = (b[8:1] == EXP_MAX) && (b[31:9] != '0);
    assign in_sgn = a[0] ^ b[0];

    logic        cap_special;
    logic        cap_dz;
    logic [31:0] cap_word;

    // Resolve special operands in priority order; the loop still runs for them
    always_comb begin
        cap_special = 1'b1;
        cap_dz      = 1'b0;
        cap_word    = {{FW{1'b0}}, {EW{1'b0}}, in_sgn};
        if (b_zero && !a_zero) begin
            cap_dz   = 1'b1;
            cap_word = {{FW{1'b0}}, EXP_MAX, in_sgn};
        end else if (a_zero && b_zero) begin
            cap_dz   = 1'b1;
            cap_word = {QNAN_FRAC, EXP_MAX, in_sgn};
        end else if (a_nan || b_nan || (a_inf && b_inf)) begin
            cap_word = {QNAN_FRAC, EXP_MAX, in_sgn};
        end else if (a_zero || b_inf) begin
            cap_word = {{FW{1'b0}}, {EW{1'b0}}, in_sgn};
        end else if (a_inf) begin
            cap_word = {{FW{1'b0}}, EXP_MAX, in_sgn};
        end else begin
            cap_special = 1'b0;
        end
    end

    // One restoring step: trial-subtract the divisor, keep the difference if non-negative
    logic [RW-1:0] mb_ext;
    logic [RW-1:0] rem_sel;
    logic          q_bit;
    assign mb_ext  = {1'b0, mb};
    assign q_bit   = (rem >= mb_ext);
    assign rem_sel = q_bit ? (rem - mb_ext) : rem;

    logic signed [XW-1:0] e_raw;
    logic signed [XW-1:0] e_fin;
    logic [FW-1:0]        frac_t;
    logic [FW-1:0]        frac_fin;
    logic                 guard;
    logic                 sticky;
    logic                 carry;
    logic [31:0]          norm_word;
    logic                 norm_ovf;
    logic                 norm_unf;

    // Normalize the quotient, round, and range-check the exponent
    always_comb begin
        frac_t = q[QW-3:1];
        guard  = q[0];
        sticky = (rem != '0);
        e_raw  = XW'(ea) - XW'(eb) + XW'(BIAS) - XW'(1);
        if (q[QW-1]) begin
            frac_t = q[QW-2:2];
            guard  = q[1];
            sticky = q[0] | (rem != '0);
            e_raw  = XW'(ea) - XW'(eb) + XW'(BIAS);
        end
`ifdef FPDIV_ROUND_EN
        {carry, frac_fin} = {1'b0, frac_t} + MW'(guard & (sticky | frac_t[0]));
`else
        carry    = 1'b0;
        frac_fin = frac_t;
`endif
        e_fin     = e_raw + XW'(carry);
        norm_ovf  = 1'b0;
        norm_unf  = 1'b0;
        norm_word = {frac_fin, e_fin[EW-1:0], sgn};
        if (e_fin >= E_OVF) begin
            norm_ovf  = 1'b1;
            norm_word = {{FW{1'b0}}, EXP_MAX, sgn};
        end else if (e_fin <= E_UNF) begin
            norm_unf  = 1'b1;
            norm_word = {{FW{1'b0}}, {EW{1'b0}}, sgn};
        end
    end

`ifndef FPDIV_ROUND_EN
    // Rounding bits only matter in the round-to-nearest build
    logic unused_round;
    assign unused_round = guard ^ sticky;
`endif

    // Control FSM with capture, divide loop, normalize and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            iter      <= '0;
            rem       <= '0;
            mb        <= '0;
            q         <= '0;
            ea        <= '0;
            eb        <= '0;
            sgn       <= 1'b0;
            spec_hit  <= 1'b0;
            spec_dz   <= 1'b0;
            spec_word <= '0;
            res_word  <= '0;
            res_ovf   <= 1'b0;
            res_unf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        ea        <= a[8:1];
                        eb        <= b[8:1];
                        sgn       <= in_sgn;
                        rem       <= RW'({1'b1, a[31:9]});
                        mb        <= {1'b1, b[31:9]};
                        q         <= '0;
                        iter      <= '0;
                        spec_hit  <= cap_special;
                        spec_dz   <= cap_dz;
                        spec_word <= cap_word;
                        dz        <= 1'b0;
                        ovf       <= 1'b0;
                        unf       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DIV;
                    end
                end
                DIV: begin
                    rem  <= rem_sel << 1;
                    q    <= {q[QW-2:0], q_bit};
                    iter <= iter + CW'(1);
                    if (iter == LAST_ITER) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    res_word <= spec_hit ? spec_word : norm_word;
                    res_ovf  <= !spec_hit && norm_ovf;
                    res_unf  <= !spec_hit && norm_unf;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    out   <= res_word;
                    dz    <= spec_dz;
                    ovf   <= res_ovf;
                    unf   <= res_unf;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
